// File: rtl/coffee_pkg.sv
// coffee_pkg: shared state encodings and coin values for the coffee vendor.
// Optional feature macro used by this design: CHANGE_EN.
package coffee_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_READY    = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_CHANGE   = 3'd4
   } state_e;

   localparam logic [1:0] COIN05_VAL = 2'd1;
   localparam logic [1:0] COIN10_VAL = 2'd2;

   // Value offered by the coin strobes in one cycle; both together give 3.
   function automatic logic [1:0] coin_value(input logic c05, input logic c10);
      logic [1:0] v05;
      logic [1:0] v10;
      v05 = c05 ? COIN05_VAL : 2'd0;
      v10 = c10 ? COIN10_VAL : 2'd0;
      return v05 + v10;
   endfunction

endpackage

// File: rtl/coffee_vendor_if.sv
// coffee_vendor_if: coin/selector inputs and display/actuator outputs of the
// coffee vendor. The slave side is the controller, the master side drives coins.
interface coffee_vendor_if #(
   parameter int N_PROD   = 3,
   parameter int CREDIT_W = 4
);
   localparam int SEL_W = $clog2(N_PROD + 1);

   logic                credit05;
   logic                credit10;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic [2:0]          current_state;
   logic [CREDIT_W-1:0] credit;
   logic [N_PROD-1:0]   dispense;
   logic                change;
   logic                coin_reject;
   logic                busy;

   modport master (
      output credit05, credit10, sel, cancel,
      input  current_state, credit, dispense, change, coin_reject, busy
   );

   modport slave (
      input  credit05, credit10, sel, cancel,
      output current_state, credit, dispense, change, coin_reject, busy
   );
endinterface

// File: rtl/credit_acc.sv
// credit_acc: saturating credit register. Priority of the controls is
// clear > subtract-PRICE > decrement-by-1 > add. A coin that is not added in
// full (blocked or clipped at LIMIT) raises reject; a clipped coin keeps the
// partial amount.
module credit_acc
   import coffee_pkg::*;
#(
   parameter int CREDIT_W = 4,
   parameter int PRICE    = 4,
   parameter int LIMIT    = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_val_i,
   input  logic                add_en_i,
   input  logic                sub_price_i,
   input  logic                dec_i,
   input  logic                clear_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic [CREDIT_W-1:0] credit_next_o,
   output logic                reject_o
);
   // Two spare bits so credit + coin can never wrap before the limit compare.
   localparam int SUM_W = CREDIT_W + 2;
   localparam logic [SUM_W-1:0]    LIMIT_S = SUM_W'(LIMIT);
   localparam logic [CREDIT_W-1:0] LIMIT_C = CREDIT_W'(LIMIT);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};

   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] credit_d;
   logic [SUM_W-1:0]    sum;
   logic                accept;
   logic                reject;

   // Next credit value and coin-reject decision.
   always_comb begin
      credit_d = credit_q;
      sum      = {2'b00, credit_q} + {{CREDIT_W{1'b0}}, coin_val_i};
      accept   = add_en_i & ~clear_i & ~sub_price_i & ~dec_i;
      if (clear_i) begin
         credit_d = ZERO_C;
      end else if (sub_price_i) begin
         credit_d = credit_q - PRICE_C;
      end else if (dec_i) begin
         credit_d = (credit_q != ZERO_C) ? (credit_q - ONE_C) : credit_q;
      end else if (add_en_i) begin
         if (sum > LIMIT_S) begin
            credit_d = LIMIT_C;
         end else begin
            credit_d = sum[CREDIT_W-1:0];
         end
      end else begin
         credit_d = credit_q;
      end
      reject = (coin_val_i != 2'd0) && (!accept || (sum > LIMIT_S));
   end

   // Credit register.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= ZERO_C;
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit_o      = credit_q;
   assign credit_next_o = credit_d;
   assign reject_o      = reject;

endmodule

// File: rtl/coffee_vendor.sv
// coffee_vendor: coin-operated beverage controller FSM with registered outputs.
// Optional feature macro: CHANGE_EN (change return and refund on cancel).
// Without CHANGE_EN credit saturates at PRICE and cancel simply clears it.
module coffee_vendor
   import coffee_pkg::*;
#(
   parameter int N_PROD     = 3,
   parameter int PRICE      = 4,
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 15
) (
   input  logic            clk,
   input  logic            rst,
   coffee_vendor_if.slave  bus
);
   localparam int SEL_W = $clog2(N_PROD + 1);
`ifdef CHANGE_EN
   localparam int LIMIT = MAX_CREDIT;
`else
   localparam int LIMIT = (PRICE < MAX_CREDIT) ? PRICE : MAX_CREDIT;
`endif
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};
   localparam logic [SEL_W-1:0]    NPROD_C = SEL_W'(N_PROD);

   state_e              state_q, state_d;
   logic [N_PROD-1:0]   dispense_q, dispense_d;
   logic                change_q, change_d;
   logic                reject_q;
   logic                busy_q, busy_d;

   logic [1:0]          coin_val;
   logic                sel_valid;
   logic                add_en, sub_price, dec, clear;
   logic [CREDIT_W-1:0] credit_now;
   logic [CREDIT_W-1:0] credit_next;
   logic                acc_reject;

   assign coin_val  = coin_value(bus.credit05, bus.credit10);
   assign sel_valid = (bus.sel != {SEL_W{1'b0}}) && (bus.sel <= NPROD_C);

   credit_acc #(
      .CREDIT_W (CREDIT_W),
      .PRICE    (PRICE),
      .LIMIT    (LIMIT)
   ) u_credit_acc (
      .clk           (clk),
      .rst           (rst),
      .coin_val_i    (coin_val),
      .add_en_i      (add_en),
      .sub_price_i   (sub_price),
      .dec_i         (dec),
      .clear_i       (clear),
      .credit_o      (credit_now),
      .credit_next_o (credit_next),
      .reject_o      (acc_reject)
   );

   // Credit controls from state and inputs only (kept apart from next-state
   // logic so the accumulator's next value never feeds back into them).
   always_comb begin
      add_en    = 1'b0;
      sub_price = 1'b0;
      dec       = 1'b0;
      clear     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            add_en = 1'b1;
         end
         ST_COLLECT: begin
            add_en = 1'b1;
`ifndef CHANGE_EN
            clear  = bus.cancel;
`endif
         end
         ST_READY: begin
            if (sel_valid) begin
               sub_price = 1'b1;
            end else begin
               add_en = 1'b1;
`ifndef CHANGE_EN
               clear  = bus.cancel;
`endif
            end
         end
         ST_DISPENSE: begin
            add_en = 1'b0;
         end
         ST_CHANGE: begin
            dec = 1'b1;
         end
         default: begin
            add_en = 1'b0;
         end
      endcase
   end

   // Next state and the values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      dispense_d = {N_PROD{1'b0}};
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (bus.cancel && (state_q == ST_COLLECT)) begin
`ifdef CHANGE_EN
               state_d = (credit_next != ZERO_C) ? ST_CHANGE : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end else if (credit_next >= PRICE_C) begin
               state_d = ST_READY;
            end else if (credit_next != ZERO_C) begin
               state_d = ST_COLLECT;
            end else begin
               state_d = state_q;
            end
         end
         ST_READY: begin
            if (sel_valid) begin
               state_d = ST_DISPENSE;
               for (int k = 0; k < N_PROD; k++) begin
                  dispense_d[k] = (bus.sel == SEL_W'(k + 1));
               end
            end else if (bus.cancel) begin
`ifdef CHANGE_EN
               state_d = ST_CHANGE;
`else
               state_d = ST_IDLE;
`endif
            end else begin
               state_d = ST_READY;
            end
         end
         ST_DISPENSE: begin
`ifdef CHANGE_EN
            state_d = (credit_now != ZERO_C) ? ST_CHANGE : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_CHANGE: begin
            // Last pulse is the one issued while credit is 1.
            state_d = (credit_now <= ONE_C) ? ST_IDLE : ST_CHANGE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef CHANGE_EN
      change_d = (state_d == ST_CHANGE);
`else
      change_d = 1'b0;
`endif
      busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dispense_q <= {N_PROD{1'b0}};
         change_q   <= 1'b0;
         reject_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dispense_q <= dispense_d;
         change_q   <= change_d;
         reject_q   <= acc_reject;
         busy_q     <= busy_d;
      end
   end

   assign bus.current_state = state_q;
   assign bus.credit        = credit_now;
   assign bus.dispense      = dispense_q;
   assign bus.change        = change_q;
   assign bus.coin_reject   = reject_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_coffee_vendor.sv
// tb_coffee_vendor: directed tests for coffee_vendor. Expectations follow the
// CHANGE_EN setting of the build.
module tb_coffee_vendor;
   import coffee_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coffee_vendor_if #(.N_PROD(3), .CREDIT_W(4)) bus ();
   coffee_vendor_if #(.N_PROD(2), .CREDIT_W(4)) bus2 ();

   coffee_vendor #(.N_PROD(3), .PRICE(4), .CREDIT_W(4), .MAX_CREDIT(15)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   coffee_vendor #(.N_PROD(2), .PRICE(4), .CREDIT_W(4), .MAX_CREDIT(15)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.credit05  = 1'b0; bus.credit10  = 1'b0; bus.sel  = 2'd0; bus.cancel  = 1'b0;
      bus2.credit05 = 1'b0; bus2.credit10 = 1'b0; bus2.sel = 2'd0; bus2.cancel = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic coin(input logic c05, input logic c10);
      bus.credit05 = c05;
      bus.credit10 = c10;
      tick();
      bus.credit05 = 1'b0;
      bus.credit10 = 1'b0;
   endtask

   task automatic check_outs(input string tag, input int st, input int cr, input int disp,
                             input int chg, input int rej, input int bsy);
      check({tag, ".state"},    32'(bus.current_state), 32'(st));
      check({tag, ".credit"},   32'(bus.credit),        32'(cr));
      check({tag, ".dispense"}, 32'(bus.dispense),      32'(disp));
      check({tag, ".change"},   32'(bus.change),        32'(chg));
      check({tag, ".reject"},   32'(bus.coin_reject),   32'(rej));
      check({tag, ".busy"},     32'(bus.busy),          32'(bsy));
   endtask

   // Counts change pulses until the controller leaves CHANGE (bounded).
   task automatic count_change(output int n);
      int guard;
      guard = 0;
      n = 0;
      while ((bus.current_state == 3'd4) && (guard < 40)) begin
         if (bus.change) n++;
         tick();
         guard++;
      end
      check("refund_idle", 32'(bus.current_state), 32'd0);
   endtask

   initial begin
      int n;
      idle_in();
      rst = 1'b1;
      do_reset();
      check_outs("reset", 0, 0, 0, 0, 0, 0);

      // Two 1.0 coins then product 1.
      coin(1'b0, 1'b1);
      check_outs("t1c1", 1, 2, 0, 0, 0, 0);
      coin(1'b0, 1'b1);
      check_outs("t1c2", 2, 4, 0, 0, 0, 0);
      bus.sel = 2'd1; tick(); bus.sel = 2'd0;
      check_outs("t1disp", 3, 0, 1, 0, 0, 1);
      tick();
      check_outs("t1idle", 0, 0, 0, 0, 0, 0);

      // 1.0, 0.5, 1.0: clipped at PRICE without change return.
      do_reset();
      coin(1'b0, 1'b1);
      coin(1'b1, 1'b0);
      check_outs("t2c2", 1, 3, 0, 0, 0, 0);
      coin(1'b0, 1'b1);
`ifdef CHANGE_EN
      check_outs("t2c3", 2, 5, 0, 0, 0, 0);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      check_outs("t2cancel", 4, 5, 0, 1, 0, 1);
      count_change(n);
      check("t2refund", 32'(n), 32'd5);
`else
      check_outs("t2c3", 2, 4, 0, 0, 1, 0);
      tick();
      check_outs("t2hold", 2, 4, 0, 0, 0, 0);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      check_outs("t2cancel", 0, 0, 0, 0, 0, 0);
`endif

      // sel and cancel together in READY: sel wins.
      do_reset();
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      bus.sel = 2'd3; bus.cancel = 1'b1; tick(); bus.sel = 2'd0; bus.cancel = 1'b0;
      check_outs("t3disp", 3, 0, 4, 0, 0, 1);
      tick();
      check_outs("t3idle", 0, 0, 0, 0, 0, 0);

      // N_PROD=2: sel=3 invalid and ignored; sel=2 dispenses.
      do_reset();
      bus2.credit10 = 1'b1; tick(); tick(); bus2.credit10 = 1'b0;
      bus2.sel = 2'd3; tick(); bus2.sel = 2'd0;
      check("t4inv.state",    32'(bus2.current_state), 32'd2);
      check("t4inv.credit",   32'(bus2.credit),        32'd4);
      check("t4inv.dispense", 32'(bus2.dispense),      32'd0);
      bus2.sel = 2'd2; tick(); bus2.sel = 2'd0;
      check("t4ok.dispense",  32'(bus2.dispense),      32'd2);
      check("t4ok.state",     32'(bus2.current_state), 32'd3);

      // rst while dispensing aborts at once.
      do_reset();
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      bus.sel = 2'd2; tick(); bus.sel = 2'd0;
      check_outs("t5disp", 3, 0, 2, 0, 0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check_outs("t5rst", 0, 0, 0, 0, 0, 0);

      // Cancel in COLLECT.
      do_reset();
      coin(1'b1, 1'b0);
      check_outs("t6coll", 1, 1, 0, 0, 0, 0);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
`ifdef CHANGE_EN
      check_outs("t6cancel", 4, 1, 0, 1, 0, 1);
      tick();
      check_outs("t6idle", 0, 0, 0, 0, 0, 0);
`else
      check_outs("t6cancel", 0, 0, 0, 0, 0, 0);
`endif

`ifdef CHANGE_EN
      // Overpay 3.0, product 3, two change pulses.
      do_reset();
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      check_outs("t7c3", 2, 6, 0, 0, 0, 0);
      bus.sel = 2'd3; tick(); bus.sel = 2'd0;
      check_outs("t7disp", 3, 2, 4, 0, 0, 1);
      tick();
      check_outs("t7ch1", 4, 2, 0, 1, 0, 1);
      tick();
      check_outs("t7ch2", 4, 1, 0, 1, 0, 1);
      tick();
      check_outs("t7idle", 0, 0, 0, 0, 0, 0);

      // Cancel refund with a coin arriving during CHANGE.
      do_reset();
      coin(1'b0, 1'b1);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      check_outs("t8ch1", 4, 2, 0, 1, 0, 1);
      coin(1'b0, 1'b1);
      check_outs("t8ch2", 4, 1, 0, 1, 1, 1);
      tick();
      check_outs("t8idle", 0, 0, 0, 0, 0, 0);

      // rst in the middle of CHANGE.
      do_reset();
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      check_outs("t9ch", 4, 6, 0, 1, 0, 1);
      tick();
      check("t9ch2.credit", 32'(bus.credit), 32'd5);
      rst = 1'b1; tick(); rst = 1'b0;
      check_outs("t9rst", 0, 0, 0, 0, 0, 0);
      tick();
      check_outs("t9post", 0, 0, 0, 0, 0, 0);

      // Saturation at MAX_CREDIT and a full 15-pulse refund.
      do_reset();
      for (int i = 0; i < 7; i++) coin(1'b0, 1'b1);
      check_outs("t10c7", 2, 14, 0, 0, 0, 0);
      coin(1'b1, 1'b1);
      check_outs("t10sat", 2, 15, 0, 0, 1, 0);
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      count_change(n);
      check("t10refund", 32'(n), 32'd15);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/coffee_vendor.md
# coffee_vendor

Parametrised coin-operated beverage controller: next generation of the lab coffee-machine FSM. It accumulates 0.5-unit coins into a saturating credit register and dispenses one of N_PROD products at a configurable price. Optionally it returns change and refunds on cancel. It sits between the coin-acceptor/selector inputs and the product actuators, and exposes its state and credit to the board display.

## Interface
- N_PROD, 3: number of products; product k is selected by sel = k+1.
- PRICE, 4: product price in 0.5 units (4 = 2.0); 1 ≤ PRICE ≤ MAX_CREDIT.
- CREDIT_W, 4: credit register width.
- MAX_CREDIT, 15: credit ceiling; must be < 2^CREDIT_W.
- SEL_W (localparam): $clog2(N_PROD+1).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- credit05  in  1  0.5-unit coin strobe, one cycle per coin.
- credit10  in  1  1.0-unit coin strobe, one cycle per coin.
- sel  in  SEL_W  product select: 0 = none; values > N_PROD are invalid.
- cancel  in  1  abort request.
- current_state  out  3  state encoding, for display.
- credit  out  CREDIT_W  current credit in 0.5 units.
- dispense  out  N_PROD  one-hot product pulse.
- change  out  1  one pulse per 0.5 unit returned.
- coin_reject  out  1  pulse when a coin is not accepted.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States: IDLE=0, COLLECT=1, READY=2, DISPENSE=3, CHANGE=4.
- Coin value per cycle: add = credit05 + 2·credit10, so both strobes together add 3.
- Coins are accepted only in IDLE, COLLECT and READY. In DISPENSE and CHANGE, any coin raises coin_reject and credit is unchanged.
- Accumulation saturates; see Configuration. Any coin that does not raise credit by its full value raises coin_reject, and the partial amount is kept.
- IDLE → COLLECT when add > 0 and credit+add < PRICE.
- IDLE or COLLECT → READY when credit+add ≥ PRICE.
- READY with valid sel (1..N_PROD):
  - next state is DISPENSE;
  - dispense[sel-1] = 1 for exactly that cycle;
  - credit -= PRICE;
  - coins arriving in the same cycle are rejected.
- Invalid or zero sel is ignored in every state. sel in IDLE/COLLECT is ignored.
- DISPENSE → CHANGE if credit > 0 and CHANGE_EN is defined; otherwise → IDLE.
- cancel in COLLECT/READY → CHANGE (CHANGE_EN defined). Without CHANGE_EN, cancel → IDLE with credit cleared. cancel in IDLE, DISPENSE or CHANGE is ignored.
- sel and cancel together in READY: sel wins.
- CHANGE: change = 1 and credit decrements by 1 each cycle. The state leaves CHANGE to IDLE in the cycle credit reaches 0.
- Credit arithmetic uses CREDIT_W+2 bits internally before the saturation compare, so no wrap-around.

## Timing
- All outputs are registered and updated on the clk rising edge.
- Reset values: current_state=IDLE, credit=0, dispense=0, change=0, coin_reject=0, busy=0.
- rst mid-dispense or mid-change aborts immediately. Remaining credit is lost and no further pulses are produced.
- Latency:
  - coin edge → credit update: 1 cycle;
  - sel sampled in READY → dispense pulse: 1 cycle, width 1 cycle;
  - first change pulse follows the DISPENSE cycle directly.
- Refund of C units occupies exactly C consecutive change cycles.

## Configuration
- CHANGE_EN defined:
  - credit saturates at MAX_CREDIT;
  - overpayment is kept and returned as change after dispensing;
  - cancel refunds all credit through CHANGE.
- CHANGE_EN undefined:
  - credit saturates at PRICE, matching the first-generation behaviour where 1.5 + 1.0 gives 2.0;
  - the CHANGE state is unreachable and the change output is tied to 0;
  - cancel clears credit without refund.

## Structure
- Shared package coffee_pkg holds:
  - the state encodings (ST_IDLE … ST_CHANGE);
  - the coin-value constants COIN05_VAL=1 and COIN10_VAL=2.
- Sub-module credit_acc holds the saturating credit register:
  - controls: add, subtract-PRICE, decrement-by-1, clear;
  - outputs: next credit and an overflow/reject flag;
  - the controller FSM instantiates it once.

## Test plan
- Default parameters, CHANGE_EN off. Coins 10,10 then sel=1 → READY after the second coin, dispense=3'b001 for one cycle, credit=0, back to IDLE.
- CHANGE_EN off. Coins 10,05,10 → credit=4 and coin_reject=1 on the third coin.
- CHANGE_EN on. Coins 10,10,10 then sel=3 → dispense=3'b100, then change high for 2 cycles, credit 2→1→0, IDLE.
- CHANGE_EN on. Coin 10 then cancel → 2 change pulses. Coins during CHANGE give coin_reject with credit unchanged.
- READY with sel=3 and cancel in the same cycle → dispense wins. sel=3 with N_PROD=2 → ignored.
- rst asserted in the middle of CHANGE → the next cycle shows all outputs at reset values and no further change pulses.
